// File: rtl/pipe_rca_pkg.sv
// Shared sizing defaults, stage-count helper and the pipeline stage record layout.
package pipe_rca_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  function automatic int stages_f(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  // Stage record at the default width; the adder declares a width-parametrised twin.
  typedef struct packed {
    logic                 valid;
    logic                 carry;
    logic [DEF_WIDTH-1:0] psum;
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b;
  } stage_t;

endpackage

// File: rtl/pipe_rca_adder_chunk.sv
// Combinational CHUNK-bit ripple of full adders; also exposes the carry into its top bit.
module rca_chunk
  import pipe_rca_pkg::*;
#(
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder, one CHUNK per register stage, valid/ready on both sides.
// Define PIPE_RCA_ADDER_SUB_EN to add the sub port (a + ~b + 1).
module pipe_rca_adder
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PIPE_RCA_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = stages_f(WIDTH, CHUNK);

  if ((CHUNK < 1) || ((WIDTH % ((CHUNK < 1) ? 1 : CHUNK)) != 0)) begin : g_bad_cfg
    $error("pipe_rca_adder: WIDTH must be a positive multiple of CHUNK (CHUNK >= 1)");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } stage_w_t;

  stage_w_t          q [STAGES];
  logic [STAGES-1:0] load;
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic              ovf_q;
  logic              unused_skew;

`ifdef PIPE_RCA_ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  // Backward load chain: an empty stage always loads, so bubbles collapse.
  always_comb begin
    load           = '0;
    load[STAGES-1] = !q[STAGES-1].valid || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      load[k] = !q[k].valid || load[k+1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    stage_w_t         src;
    logic [CHUNK-1:0] s;
    logic             co;
    logic             c_msb;
    logic [WIDTH-1:0] psum_n;

    if (k == 0) begin : g_head
      always_comb begin
        src       = '0;
        src.valid = in_valid;
        src.carry = cin_eff;
        src.a     = a;
        src.b     = b_eff;
      end
    end else begin : g_body
      assign src = q[k-1];
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (src.a[k*CHUNK +: CHUNK]),
      .b        (src.b[k*CHUNK +: CHUNK]),
      .ci       (src.carry),
      .s        (s),
      .co       (co),
      .c_msb_in (c_msb)
    );

    always_comb begin
      psum_n                   = src.psum;
      psum_n[k*CHUNK +: CHUNK] = s;
    end

    // Operands travel whole; each stage only consumes its own chunk of them.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q[k] <= '0;
      end else if (load[k]) begin
        q[k].valid <= src.valid;
        q[k].carry <= co;
        q[k].psum  <= psum_n;
        q[k].a     <= src.a;
        q[k].b     <= src.b;
      end
    end

    if (k == STAGES - 1) begin : g_tail
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (load[k]) begin
          ovf_q <= c_msb ^ co;
        end
      end
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = c_msb;
    end
  end

  assign unused_skew = ^{q[STAGES-1].a, q[STAGES-1].b};

  assign in_ready  = load[0];
  assign out_valid = q[STAGES-1].valid;
  assign sum       = q[STAGES-1].psum;
  assign cout      = q[STAGES-1].carry;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Randomised and directed bench for pipe_rca_adder (WIDTH=16, CHUNK=4) against an arithmetic model.
module tb_pipe_rca_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  a;
  logic [WIDTH-1:0]  b;
  logic              cin;
  logic              sub;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sum;
  logic              cout;
  logic              ovf;

  int errors = 0;
  int checks = 0;
  logic [17:0] expq [$];

  always #5 clk = ~clk;

  pipe_rca_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef PIPE_RCA_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // Result as {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic s);
    int ua, ub, uc, sx, sy, r, sr;
    logic [15:0] rs;
    logic co, ov;
    ua = x; ub = y; uc = ci;
    sx = $signed(x); sy = $signed(y);
    if (s) begin
      r = ua - ub; co = (ua >= ub); sr = sx - sy;
    end else begin
      r = ua + ub + uc; co = (r > 65535); sr = sx + sy + uc;
    end
    rs = r[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, rs};
  endfunction

  task automatic rand_op();
    a   = 16'($urandom);
    b   = 16'($urandom);
    cin = 1'($urandom);
`ifdef PIPE_RCA_ADDER_SUB_EN
    sub = 1'($urandom);
`else
    sub = 1'b0;
`endif
  endtask

  // One clock: sample at the falling edge, record accepted inputs, return #1 after the rising edge.
  task automatic tick(output logic ov, output logic rdy, output logic ti, output logic to,
                      output logic [17:0] obs);
    @(negedge clk);
    ov  = out_valid;
    rdy = in_ready;
    ti  = in_valid && in_ready;
    to  = out_valid && out_ready;
    obs = {ovf, cout, sum};
    if (ti) expq.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [15:0] x, input logic [15:0] y, input logic ci,
                          input logic s, output logic [17:0] res, output int lat,
                          output logic ok);
    logic ov, rdy, ti, to;
    logic [17:0] obs;
    out_ready = 1'b1;
    a = x; b = y; cin = ci; sub = s;
    in_valid = 1'b1;
    ok = 1'b0; lat = 0; res = '0; ti = 1'b0;
    for (int i = 0; i < 20 && !ti; i++) tick(ov, rdy, ti, to, obs);
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(ov, rdy, ti, to, obs);
      lat++;
      if (to) begin
        res = obs; ok = 1'b1;
        break;
      end
    end
    expq.delete();
  endtask

  task automatic test_reset();
    logic ov, rdy, ti, to;
    logic [17:0] obs;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; sub = 1'b0;
    rand_op();
    sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; in_valid = 1'b0;
    tick(ov, rdy, ti, to, obs);
    checks++;
    if (ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
    checks++;
    if (obs !== 18'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 00000", obs); end
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", rdy); end
    expq.delete();
  endtask

  task automatic test_latency();
    logic [17:0] res; int lat; logic ok;
    send_one(16'h1234, 16'h1111, 1'b0, 1'b0, res, lat, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL latency_timeout: got no result expected one"); end
    checks++;
    if (lat != STAGES) begin errors++; $display("FAIL latency_cycles: got %0d expected %0d", lat, STAGES); end
    checks++;
    if (res !== 18'h02345) begin errors++; $display("FAIL latency_sum: got %h expected 02345", res); end
  endtask

  task automatic test_carry_ripple();
    logic [17:0] res; int lat; logic ok;
    send_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, res, lat, ok);
    checks++;
    if (!ok || res !== 18'h10000) begin errors++; $display("FAIL carry_ripple: got %h expected 10000", res); end
  endtask

  task automatic test_signed_overflow();
    logic [17:0] res; int lat; logic ok;
    send_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, res, lat, ok);
    checks++;
    if (!ok || res !== 18'h28000) begin errors++; $display("FAIL ovf_pos: got %h expected 28000", res); end
    send_one(16'h8000, 16'h8000, 1'b0, 1'b0, res, lat, ok);
    checks++;
    if (!ok || res !== 18'h30000) begin errors++; $display("FAIL ovf_neg: got %h expected 30000", res); end
  endtask

  task automatic test_back_to_back();
    logic ov, rdy, ti, to;
    logic [17:0] obs, exp;
    int sent = 0, rcv = 0, gaps = 0, stalls = 0;
    out_ready = 1'b1;
    rand_op();
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 400 && rcv < 100; cyc++) begin
      tick(ov, rdy, ti, to, obs);
      if (in_valid) begin
        if (!rdy) stalls++;
        if (ti) begin
          sent++;
          if (sent == 100) in_valid = 1'b0; else rand_op();
        end
      end
      if (to) begin
        rcv++;
        exp = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL stream_result %0d: got %h expected %h", rcv, obs, exp); end
      end else if (rcv > 0 && rcv < 100) begin
        gaps++;
      end
    end
    checks++;
    if (rcv != 100) begin errors++; $display("FAIL stream_count: got %0d expected 100", rcv); end
    checks++;
    if (gaps != 0) begin errors++; $display("FAIL stream_gaps: got %0d expected 0", gaps); end
    checks++;
    if (stalls != 0) begin errors++; $display("FAIL stream_stalls: got %0d expected 0", stalls); end
    expq.delete();
  endtask

  task automatic test_backpressure();
    logic ov, rdy, ti, to, stable, have_first;
    logic [17:0] obs, first, exp;
    int acc = 0, rcv = 0;
    out_ready = 1'b0;
    rand_op();
    in_valid = 1'b1;
    stable = 1'b1; have_first = 1'b0; first = '0; rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(ov, rdy, ti, to, obs);
      if (ti) begin acc++; rand_op(); end
      if (ov) begin
        if (!have_first) begin first = obs; have_first = 1'b1; end
        else if (obs !== first) stable = 1'b0;
      end
    end
    checks++;
    if (acc != STAGES) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", acc, STAGES); end
    checks++;
    if (rdy !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b expected 0", rdy); end
    checks++;
    if (!(have_first && stable)) begin errors++; $display("FAIL bp_stable: got seen=%b stable=%b expected 1 1", have_first, stable); end
    out_ready = 1'b1;
    tick(ov, rdy, ti, to, obs);
    checks++;
    if (!(ti && to)) begin errors++; $display("FAIL bp_release_move: got in=%b out=%b expected 1 1", ti, to); end
    if (ti) begin acc++; rand_op(); end
    if (to) begin
      rcv++;
      exp = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL bp_result %0d: got %h expected %h", rcv, obs, exp); end
    end
    for (int cyc = 0; cyc < 100 && rcv < 10; cyc++) begin
      if (acc >= 10) in_valid = 1'b0;
      tick(ov, rdy, ti, to, obs);
      if (ti) begin acc++; rand_op(); end
      if (to) begin
        rcv++;
        exp = (expq.size() > 0) ? expq.pop_front() : 18'h3FFFF;
        checks++;
        if (obs !== exp) begin errors++; $display("FAIL bp_result %0d: got %h expected %h", rcv, obs, exp); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (rcv != 10 || expq.size() != 0) begin
      errors++; $display("FAIL bp_drain: got %0d results, %0d pending expected 10, 0", rcv, expq.size());
    end
    expq.delete();
  endtask

  task automatic test_midflight_reset();
    logic ov, rdy, ti, to;
    logic [17:0] obs, res;
    int emitted = 0, acc = 0, lat;
    logic ok;
    out_ready = 1'b1;
    rand_op();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(ov, rdy, ti, to, obs);
      if (ti) begin acc++; rand_op(); end
      if (to) emitted++;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick(ov, rdy, ti, to, obs);
    if (to) emitted++;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(ov, rdy, ti, to, obs);
      if (to) emitted++;
    end
    checks++;
    if (acc != 3 || emitted != 0) begin
      errors++; $display("FAIL midreset_flush: got acc=%0d emitted=%0d expected 3 0", acc, emitted);
    end
    expq.delete();
    send_one(16'h00FF, 16'h0001, 1'b0, 1'b0, res, lat, ok);
    checks++;
    if (!ok || res !== 18'h00100) begin errors++; $display("FAIL midreset_next: got %h expected 00100", res); end
  endtask

`ifdef PIPE_RCA_ADDER_SUB_EN
  task automatic test_sub();
    logic [17:0] res; int lat; logic ok;
    send_one(16'h0005, 16'h0007, 1'b0, 1'b1, res, lat, ok);
    checks++;
    if (!ok || res !== 18'h0FFFE) begin errors++; $display("FAIL sub_borrow: got %h expected 0fffe", res); end
    send_one(16'h8000, 16'h0001, 1'b1, 1'b1, res, lat, ok);
    checks++;
    if (!ok || res !== 18'h37FFF) begin errors++; $display("FAIL sub_ovf: got %h expected 37fff", res); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_carry_ripple();
    test_signed_overflow();
    test_back_to_back();
    test_backpressure();
    test_midflight_reset();
`ifdef PIPE_RCA_ADDER_SUB_EN
    test_sub();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_rca_adder.md
Name: pipe_rca_adder

Overview:
- Parametrised, pipelined ripple-carry adder for the half-precision FP adder datapath (exponent/mantissa sums).
- Built from full-adder chunks; operand width is split into STAGES = WIDTH/CHUNK register stages, one chunk per stage.
- Valid/ready handshake on both sides; full throughput of one operation per cycle; stalls under backpressure without losing data.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits resolved per pipeline stage; minimum 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operand set present.
- in_ready  output  1  block accepts operands this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result present.
- out_ready  input  1  downstream accepts the result.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  unsigned carry-out.
- ovf  output  1  signed two's-complement overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset: synchronous, active-low, sampled on rising clk. All stage valid bits, data/skew registers, sum, cout and ovf clear to 0. out_valid = 0. in_ready = 1 in the first cycle after reset releases.
- Reset mid-operation discards all in-flight results; nothing is emitted afterwards.
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - The source holds a, b and cin stable while in_valid && !in_ready.
- Stage k (0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of the skewed a/b, using the carry registered by stage k-1 (cin for stage 0).
  - Registers the partial sum bits, the carry-out, and the undelivered upper operand bits (skew).
  - Lower result bits pass forward unchanged.
- Advance rule: stage k loads when it is empty OR stage k+1 loads; the last stage loads when it is empty OR out_ready. Bubbles collapse, so an empty stage never blocks upstream.
- in_ready = stage 0 may load. This is a combinational path from out_ready through the chain; this is accepted.
- Latency: an input accepted at edge t is presented with out_valid = 1 after edge t+STAGES-1, provided there are no stalls. With out_ready held high, one result per cycle.
- Output stability: while out_valid && !out_ready, sum, cout and ovf hold stable.
- Ordering: results leave in acceptance order; there is no reordering or dropping.
- Full pipeline: STAGES results held, out_ready = 0 → in_ready = 0. A simultaneous out_ready = 1 and in_valid = 1 moves the whole chain and accepts the new input in the same cycle.
- Empty pipeline: out_valid = 0; the sum/cout/ovf values are don't-care but are not X after reset.
- Wrap-around: sum is modulo 2^WIDTH; cout and ovf report the boundary crossing.
- Elaboration: WIDTH % CHUNK != 0 or CHUNK < 1 triggers $error.

Optional Feature:
- Macro: PIPE_RCA_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a/b.
  - sub = 1 computes a + ~b + 1 (cin ignored). cout = 1 means no borrow; ovf is the signed subtract overflow.
  - sub = 0 behaves as the add path.
- Undefined: no sub port; add-only, with identical timing.

Decomposition:
- Package pipe_rca_pkg:
  - Default WIDTH/CHUNK localparams.
  - Function stages_f(WIDTH, CHUNK).
  - Packed typedef stage_t {valid, carry, partial sum, skewed a, skewed b}.
- Sub-module rca_chunk: combinational CHUNK-bit ripple of full adders, ports a, b, ci, s, co, c_msb_in. Instantiated once per stage; the last stage's c_msb_in drives ovf.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 → out_valid = 0, sum = 0, cout = 0, ovf = 0; in_ready = 1 on the first cycle after release.
- Latency/streaming: WIDTH = 16, CHUNK = 4, out_ready = 1; send 0x1234 + 0x1111, cin = 0 → sum 0x2345 with out_valid after 4 cycles; 100 back-to-back random ops → one result per cycle, matching the model.
- Carry ripple across all stages: 0xFFFF + 0x0000, cin = 1 → sum 0x0000, cout = 1, ovf = 0.
- Signed overflow: 0x7FFF + 0x0001 → sum 0x8000, cout = 0, ovf = 1; 0x8000 + 0x8000 → sum 0x0000, cout = 1, ovf = 1.
- Backpressure: out_ready = 0 for 10 cycles while streaming → in_ready drops after 4 acceptances; outputs stay stable; after release, all results arrive in order with none lost or duplicated.
- Mid-flight reset: 3 ops in flight, pulse rst_n low for 1 cycle → none emitted; next op returns correctly. With PIPE_RCA_ADDER_SUB_EN: 0x0005 - 0x0007 → 0xFFFE, cout = 0.
